// File: rtl/mips_dump_pkg.sv
// Shared types and constants for the post-run memory dump engine.
package mips_dump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/dump_fifo2.sv
// Two-entry FIFO holding {last, addr, data} words between the memory read port and the dump stream.
module dump_fifo2
    import mips_dump_pkg::*;
#(
    parameter int unsigned W = 43
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk1) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/mips_mem_dump.sv
// Post-run memory readback: on the HALTED rising edge, reads word_count words from start_addr
// and streams {addr, data, last} over a valid/ready interface.
module mips_mem_dump
    import mips_dump_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              halted,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned REM_W = ADDR_W + 1;
    localparam int unsigned PAY_W = 1 + ADDR_W + DATA_W;

    state_t            r_state;
    logic              r_halted_q;
    logic [ADDR_W-1:0] r_addr;
    logic [REM_W-1:0]  r_remaining;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [ADDR_W-1:0] r_inflight_addr;

    logic              w_arm;
    logic              w_issue;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [CNT_W-1:0]  w_count;
    logic [2:0]        w_occ;
    logic [PAY_W-1:0]  w_push_data;
    logic [PAY_W-1:0]  w_head;

    assign w_arm = halted && !r_halted_q;
    assign w_pop = dump_valid && dump_ready;

    // Credit check counts words buffered plus the read in flight, net of this cycle's pop.
    assign w_occ   = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue = (r_state == RUN) && (r_remaining != '0) && (w_occ < 3'(FIFO_DEPTH));

    assign mem_rd_en   = w_issue;
    assign mem_rd_addr = r_addr;
    assign w_push_data = {r_inflight_last, r_inflight_addr, mem_rd_data};

    assign dump_valid = !w_empty;
    assign {dump_last, dump_addr, dump_data} = w_head;
    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

    dump_fifo2 #(
        .W(PAY_W)
    ) u_fifo (
        .clk1      (clk1),
        .reset     (reset),
        .push      (r_inflight),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state         <= IDLE;
            r_halted_q      <= 1'b1;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_inflight_addr <= '0;
        end else begin
            r_halted_q <= halted;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_addr          <= r_addr + ADDR_W'(1);
                r_remaining     <= r_remaining - REM_W'(1);
                r_inflight_addr <= r_addr;
                r_inflight_last <= (r_remaining == REM_W'(1));
            end
            case (r_state)
                IDLE: begin
                    if (w_arm) begin
                        r_addr      <= start_addr;
                        r_remaining <= word_count;
                        r_state     <= (word_count == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_pop && dump_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!halted) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk1) disable iff (reset)
        (r_inflight && w_full) |-> w_pop);

endmodule

// File: tb/tb_mips_mem_dump.sv
// Directed self-checking bench for mips_mem_dump with a one-cycle-latency memory model.
module tb_mips_mem_dump;

    logic        clk1;
    logic        reset;
    logic        halted;
    logic [9:0]  start_addr;
    logic [10:0] word_count;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [9:0]  dump_addr;
    logic        dump_last;
    logic        busy;
    logic        done;

    logic [31:0] mem [1024];
    int          errors;
    int          checks;
    int          mon_rd;
    int          mon_valid;

    mips_mem_dump #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk1        (clk1),
        .reset       (reset),
        .halted      (halted),
        .start_addr  (start_addr),
        .word_count  (word_count),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .dump_addr   (dump_addr),
        .dump_last   (dump_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    always @(posedge clk1) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (mem_rd_en) mon_rd <= mon_rd + 1;
        if (dump_valid) mon_valid <= mon_valid + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Leaves the bench sampling in the first cycle after the arming edge.
    task automatic arm(input logic [9:0] sa, input logic [10:0] cnt);
        halted = 1'b0;
        tick();
        start_addr = sa;
        word_count = cnt;
        halted     = 1'b1;
        tick();
    endtask

    task automatic collect(input string tag, input logic [9:0] base, input int n);
        int got;
        logic [9:0] a;
        got = 0;
        dump_ready = 1'b1;
        for (int cyc = 0; cyc < 64 && got < n; cyc++) begin
            if (dump_valid && dump_ready) begin
                a = base + 10'(got);
                check({tag, "_addr"}, 32'(dump_addr), 32'(a));
                check({tag, "_data"}, dump_data, mem[a]);
                check({tag, "_last"}, 32'(dump_last), 32'(got == n - 1));
                got++;
            end
            tick();
        end
        check({tag, "_words"}, 32'(got), 32'(n));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int v0;
        errors = 0;
        checks = 0;
        mon_rd = 0;
        mon_valid = 0;
        mem_rd_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 3 + 1);
        mem[198] = 32'd5040;
        mem[199] = 32'd0;
        mem[200] = 32'd7;
        mem[1022] = 32'hCAFE_0001;
        mem[1023] = 32'hCAFE_0002;
        mem[0]    = 32'hCAFE_0003;
        mem[1]    = 32'hCAFE_0004;

        reset = 1'b1;
        halted = 1'b1;
        dump_ready = 1'b0;
        start_addr = '0;
        word_count = '0;
        tick();
        tick();
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_no_arm", 32'(busy), 32'd0);

        // Factorial readback with ready high
        dump_ready = 1'b1;
        arm(10'd198, 11'd3);
        start_addr = 10'd0;
        word_count = 11'd0;
        check("t1_n1_rd_en", 32'(mem_rd_en), 32'd1);
        check("t1_n1_rd_addr", 32'(mem_rd_addr), 32'd198);
        check("t1_n1_valid", 32'(dump_valid), 32'd0);
        check("t1_n1_busy", 32'(busy), 32'd1);
        tick();
        check("t1_n2_rd_addr", 32'(mem_rd_addr), 32'd199);
        check("t1_n2_valid", 32'(dump_valid), 32'd0);
        tick();
        check("t1_n3_valid", 32'(dump_valid), 32'd1);
        check("t1_n3_addr", 32'(dump_addr), 32'd198);
        check("t1_n3_data", dump_data, 32'd5040);
        check("t1_n3_last", 32'(dump_last), 32'd0);
        check("t1_n3_rd_addr", 32'(mem_rd_addr), 32'd200);
        tick();
        check("t1_n4_addr", 32'(dump_addr), 32'd199);
        check("t1_n4_data", dump_data, 32'd0);
        check("t1_n4_last", 32'(dump_last), 32'd0);
        check("t1_n4_rd_en", 32'(mem_rd_en), 32'd0);
        tick();
        check("t1_n5_valid", 32'(dump_valid), 32'd1);
        check("t1_n5_addr", 32'(dump_addr), 32'd200);
        check("t1_n5_data", dump_data, 32'd7);
        check("t1_n5_last", 32'(dump_last), 32'd1);
        tick();
        check("t1_n6_valid", 32'(dump_valid), 32'd0);
        check("t1_n6_done", 32'(done), 32'd1);
        check("t1_n6_busy", 32'(busy), 32'd0);
        tick();
        check("t1_done_held", 32'(done), 32'd1);
        halted = 1'b0;
        tick();
        check("t1_done_clear", 32'(done), 32'd0);

        // Backpressure: ready low for five cycles after the first word appears
        dump_ready = 1'b0;
        rd0 = mon_rd;
        arm(10'd300, 11'd4);
        for (int cyc = 0; cyc < 8 && !dump_valid; cyc++) tick();
        check("t2_first_valid", 32'(dump_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("t2_hold_addr", 32'(dump_addr), 32'd300);
            check("t2_hold_data", dump_data, mem[300]);
            check("t2_hold_rd_en", 32'(mem_rd_en), 32'd0);
            tick();
        end
        check("t2_read_ahead", 32'(mon_rd - rd0), 32'd2);
        collect("t2", 10'd300, 4);
        check("t2_total_reads", 32'(mon_rd - rd0), 32'd4);

        // Zero-length dump
        rd0 = mon_rd;
        v0 = mon_valid;
        arm(10'd500, 11'd0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) tick();
        check("t3_no_reads", 32'(mon_rd - rd0), 32'd0);
        check("t3_no_valid", 32'(mon_valid - v0), 32'd0);
        check("t3_done_held", 32'(done), 32'd1);

        // Address wrap
        arm(10'd1022, 11'd4);
        collect("t4", 10'd1022, 4);

        // Reset after the second word while halted stays high
        dump_ready = 1'b1;
        arm(10'd400, 11'd4);
        tick();
        tick();
        check("t5_w0_addr", 32'(dump_addr), 32'd400);
        tick();
        check("t5_w1_addr", 32'(dump_addr), 32'd401);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_valid", 32'(dump_valid), 32'd0);
        check("t5_rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        rd0 = mon_rd;
        v0 = mon_valid;
        for (int k = 0; k < 6; k++) tick();
        check("t5_no_redump_rd", 32'(mon_rd - rd0), 32'd0);
        check("t5_no_redump_valid", 32'(mon_valid - v0), 32'd0);
        check("t5_no_done", 32'(done), 32'd0);
        arm(10'd400, 11'd4);
        collect("t5", 10'd400, 4);

        // Re-arm for a single word
        arm(10'd200, 11'd1);
        collect("t6", 10'd200, 1);
        check("t6_value", 32'(mem[200]), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
